alu_carry_chain_seq: RTL and testbench
======================================

Name: alu_carry_chain_seq

Overview:
- Multi-word add/subtract sequencer on the Slipstream ALU side.
- Produces and owns the carry that the ALU carry-input select consumes: generates carry per word, chains it across words, and holds the final carry as a flag for later ADC/SBC operations.
- Operands stream in one word per handshake; results stream out through a one-entry output register.
- A flag set (C, Z, V) is presented at completion.

Parameters:
- WIDTH, 16, data word width in bits.
- MAXWORDS, 8, maximum words per operation; COUNT width is clog2(MAXWORDS+1).

Ports:
- MasterClock  in  1  system clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  begin operation; sampled only in IDLE.
- OP  in  2  0=ADD, 1=ADC, 2=SUB, 3=SBC; captured at START.
- COUNT  in  clog2(MAXWORDS+1)  words in operation; captured at START.
- A_IN  in  WIDTH  operand A word, least significant word first.
- B_IN  in  WIDTH  operand B word.
- IN_VALID  in  1  operand word pair valid.
- IN_READY  out  1  sequencer accepts operand pair this cycle.
- R_OUT  out  WIDTH  result word.
- R_VALID  out  1  R_OUT holds an unconsumed word.
- R_READY  in  1  downstream accepts R_OUT.
- CF  out  1  carry flag (SUB/SBC: 1 = no borrow).
- ZF  out  1  all result words of the last operation were zero.
- VF  out  1  signed overflow of the most significant word.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse when the operation completes.

Behaviour:
- Reset values: IN_READY=0, R_OUT=0, R_VALID=0, CF=0, ZF=0, VF=0, BUSY=0, DONE=0; state=IDLE. RESET mid-operation abandons it with no DONE.
- States:
  - IDLE: START=1 and COUNT!=0 → capture OP and COUNT into words_left, zacc=1 → RUN. START with COUNT=0, or START outside IDLE, is ignored.
  - RUN: IN_READY = (words_left!=0) and (!R_VALID or R_READY).
  - On IN_VALID & IN_READY:
    - {cout, sum} = A_IN + (sub ? ~B_IN : B_IN) + cin, computed at WIDTH+1 bits.
    - R_OUT <= sum; R_VALID <= 1.
    - chain carry <= cout; zacc <= zacc & (sum==0); words_left decrements.
  - When the last word is accepted → DRAIN.
  - DRAIN: IN_READY=0. When R_VALID=0, or R_READY=1 in that cycle → FIN.
  - FIN: CF <= chain carry; ZF <= zacc; VF <= overflow of the last word. VF = (a_msb == b'_msb) & (sum_msb != a_msb), where b' = B_IN or ~B_IN as used. DONE=1 for this cycle → IDLE. Flags update only in FIN.
- Carry-in selection:
  - First word: ADD=0, SUB=1, ADC/SBC=CF.
  - Subsequent words: chain carry.
- Output handshake:
  - R_VALID clears on R_READY unless a new word loads in the same cycle; simultaneous load and consume keeps R_VALID=1 with the new word.
  - R_OUT holds stable while R_VALID=1 and R_READY=0.
- Latency: operand accepted at edge n → R_VALID at n+1. Throughput is one word per cycle with R_READY held high. DONE follows the edge that clears the last R_VALID by one cycle.
- COUNT=MAXWORDS is legal. words_left never underflows.

Decomposition:
- Shared package alu_seq_pkg holds:
  - the OP encoding enum (ADD, ADC, SUB, SBC);
  - the state enum (IDLE, RUN, DRAIN, FIN);
  - a flags struct {C, Z, V}.
- One natural sub-module: alu_word_adder. It is combinational WIDTH-bit add with invert-B and carry-in, and outputs sum, cout and v. The parent holds all sequential state.

Test Plan:
1. ADD, COUNT=2, words (A=FFFF, B=0001) then (A=0001, B=0000) → R_OUT 0000 then 0002; CF=0, ZF=0, VF=0; DONE once.
2. SUB, COUNT=1, A=0000, B=0001 → R_OUT FFFF, CF=0, ZF=0, VF=0. Follow with SBC, COUNT=1, A=0005, B=0001 → R_OUT 0003 (borrow consumed), CF=1.
3. ADD, COUNT=1, A=8000, B=8000 → R_OUT 0000, CF=1, ZF=1, VF=1. Then ADC, A=0000, B=0000 → R_OUT 0001, ZF=0.
4. ADD, COUNT=3 with R_READY low for 4 cycles after the first result → IN_READY=0 and R_OUT stable while stalled; all three words are delivered in order once R_READY rises; DONE comes after the third word is consumed.
5. RESET asserted in RUN after one of two words → every output returns to its reset value, no DONE, and the next ADC uses cin=0.
6. START with COUNT=0, and START pulsed while BUSY → both ignored: no state change, flags unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types for the multi-word add/subtract sequencer.
//   op_e    : operation encoding presented on OP (ADD, ADC, SUB, SBC)
//   state_e : sequencer states (IDLE, RUN, DRAIN, FIN)
//   flags_t : flag set {C, Z, V} presented at completion
// Helpers decode the operation into adder controls.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_ADC = 2'd1,
        OP_SUB = 2'd2,
        OP_SBC = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    typedef struct packed {
        logic c;
        logic z;
        logic v;
    } flags_t;

    // Subtraction is done as A + ~B + cin, so SUB/SBC invert B.
    function automatic logic op_is_sub(input op_e op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    // Carry into the least significant word. Plain SUB starts with
    // cin=1 (two's complement); ADC/SBC continue from the held carry.
    function automatic logic first_cin(input op_e op, input logic held_c);
        logic cin;
        case (op)
            OP_ADD:  cin = 1'b0;
            OP_SUB:  cin = 1'b1;
            default: cin = held_c;
        endcase
        return cin;
    endfunction

endpackage

// File: rtl/alu_word_adder.sv
// Combinational single-word adder with optional B inversion and carry-in.
//   a, b     : operand words
//   invert_b : use ~b instead of b (subtraction)
//   cin      : carry in
//   sum      : WIDTH-bit result
//   cout     : carry out of the top bit
//   v        : signed overflow of this word
module alu_word_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             v
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   total;

    assign b_eff = invert_b ? ~b : b;
    assign total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign sum   = total[WIDTH-1:0];
    assign cout  = total[WIDTH];
    // Overflow: both addends share a sign that the sum does not.
    assign v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_carry_chain_seq.sv
// Multi-word add/subtract sequencer. Operand word pairs stream in least
// significant first; each word's carry chains into the next, and the final
// carry is held as CF for later ADC/SBC operations.
//   MasterClock, RESET     : clock, asynchronous active-high reset
//   START, OP, COUNT       : launch an operation (sampled in IDLE only)
//   A_IN, B_IN, IN_VALID   : operand stream, IN_READY back-pressure
//   R_OUT, R_VALID, R_READY: one-entry result register and handshake
//   CF, ZF, VF             : flags, updated only at completion
//   BUSY, DONE             : activity indicator, one-cycle completion pulse
module alu_carry_chain_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAXWORDS = 8,
    localparam int CW      = $clog2(MAXWORDS + 1)
) (
    input  logic             MasterClock,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [CW-1:0]    COUNT,
    input  logic [WIDTH-1:0] A_IN,
    input  logic [WIDTH-1:0] B_IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] R_OUT,
    output logic             R_VALID,
    input  logic             R_READY,
    output logic             CF,
    output logic             ZF,
    output logic             VF,
    output logic             BUSY,
    output logic             DONE
);

    state_e           state_reg, state_next;
    op_e              op_reg;
    logic [CW-1:0]    words_left_reg;
    logic             first_reg;
    logic             chain_reg;
    logic             zacc_reg;
    logic             v_last_reg;
    logic [WIDTH-1:0] r_out_reg;
    logic             r_valid_reg;
    flags_t           flags_reg;

    logic             in_ready;
    logic             accept;
    logic             start_ok;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             v;

    assign start_ok = (state_reg == ST_IDLE) && START && (COUNT != '0);
    assign accept   = IN_VALID && in_ready;
    assign cin      = first_reg ? first_cin(op_reg, flags_reg.c) : chain_reg;

    alu_word_adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a       (A_IN),
        .b       (B_IN),
        .invert_b(op_is_sub(op_reg)),
        .cin     (cin),
        .sum     (sum),
        .cout    (cout),
        .v       (v)
    );

    // State register
    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and input handshake
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Accept only if the result register is free or being emptied.
                in_ready = (words_left_reg != '0) && (!r_valid_reg || R_READY);
                if (IN_VALID && in_ready && (words_left_reg == CW'(1))) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_valid_reg || R_READY) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            op_reg         <= OP_ADD;
            words_left_reg <= '0;
            first_reg      <= 1'b0;
            chain_reg      <= 1'b0;
            zacc_reg       <= 1'b0;
            v_last_reg     <= 1'b0;
            r_out_reg      <= '0;
            r_valid_reg    <= 1'b0;
            flags_reg      <= '0;
        end else begin
            if (start_ok) begin
                op_reg         <= op_e'(OP);
                words_left_reg <= COUNT;
                zacc_reg       <= 1'b1;
                first_reg      <= 1'b1;
            end

            if (accept) begin
                r_out_reg      <= sum;
                words_left_reg <= words_left_reg - CW'(1);
                chain_reg      <= cout;
                zacc_reg       <= zacc_reg && (sum == '0);
                v_last_reg     <= v;
                first_reg      <= 1'b0;
            end

            // A load in the same cycle as a consume keeps the register full.
            if (accept) begin
                r_valid_reg <= 1'b1;
            end else if (R_READY) begin
                r_valid_reg <= 1'b0;
            end

            if (state_reg == ST_FIN) begin
                flags_reg.c <= chain_reg;
                flags_reg.z <= zacc_reg;
                flags_reg.v <= v_last_reg;
            end
        end
    end

    assign IN_READY = in_ready;
    assign R_OUT    = r_out_reg;
    assign R_VALID  = r_valid_reg;
    assign CF       = flags_reg.c;
    assign ZF       = flags_reg.z;
    assign VF       = flags_reg.v;
    assign BUSY     = (state_reg != ST_IDLE);
    assign DONE     = (state_reg == ST_FIN);

endmodule

// File: tb/tb_alu_carry_chain_seq.sv
module tb_alu_carry_chain_seq;

    logic        MasterClock;
    logic        RESET;
    logic        START;
    logic [1:0]  OP;
    logic [3:0]  COUNT;
    logic [15:0] A_IN;
    logic [15:0] B_IN;
    logic        IN_VALID;
    logic        IN_READY;
    logic [15:0] R_OUT;
    logic        R_VALID;
    logic        R_READY;
    logic        CF;
    logic        ZF;
    logic        VF;
    logic        BUSY;
    logic        DONE;

    alu_carry_chain_seq #(.WIDTH(16), .MAXWORDS(8)) dut (
        .MasterClock(MasterClock),
        .RESET      (RESET),
        .START      (START),
        .OP         (OP),
        .COUNT      (COUNT),
        .A_IN       (A_IN),
        .B_IN       (B_IN),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .R_OUT      (R_OUT),
        .R_VALID    (R_VALID),
        .R_READY    (R_READY),
        .CF         (CF),
        .ZF         (ZF),
        .VF         (VF),
        .BUSY       (BUSY),
        .DONE       (DONE)
    );

    initial MasterClock = 1'b0;
    always #5 MasterClock = ~MasterClock;

    int          checks   = 0;
    int          failures = 0;

    logic [15:0] a_w [8];
    logic [15:0] b_w [8];
    logic [15:0] exp_w [8];
    logic        exp_cf, exp_zf, exp_vf;
    logic        model_cf = 1'b0;   // carry the bench expects the DUT to hold

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-number reference: treat the words as one cnt*16-bit integer.
    task automatic compute_expected(input logic [1:0] op, input int cnt);
        logic [135:0] a_big, b_big, total;
        logic         sub, cin;
        int           top;
        a_big = '0;
        b_big = '0;
        sub   = (op == 2'd2) || (op == 2'd3);
        for (int i = 0; i < cnt; i++) begin
            a_big[16*i +: 16] = a_w[i];
            b_big[16*i +: 16] = sub ? ~b_w[i] : b_w[i];
        end
        cin   = (op == 2'd0) ? 1'b0 : (op == 2'd2) ? 1'b1 : model_cf;
        total = a_big + b_big + {135'd0, cin};
        exp_cf = total[16*cnt];
        exp_zf = 1'b1;
        for (int i = 0; i < cnt; i++) begin
            exp_w[i] = total[16*i +: 16];
            if (exp_w[i] != 16'h0) exp_zf = 1'b0;
        end
        top    = 16*cnt - 1;
        exp_vf = (a_big[top] == b_big[top]) && (total[top] != a_big[top]);
    endtask

    // mode 0: R_READY high; 1: R_READY low 4 cycles after first result; 2: random
    task automatic run_op(input string name, input logic [1:0] op, input int cnt,
                          input int mode, input bit glitch);
        int   in_idx, out_idx, stall_left;
        bit   done_seen, prev_hold;
        logic [15:0] prev_r;
        compute_expected(op, cnt);
        @(negedge MasterClock);
        START = 1'b1;
        OP    = op;
        COUNT = 4'(cnt);
        @(negedge MasterClock);
        START = 1'b0;
        chk({name, "_busy"}, {31'd0, BUSY}, 32'd1);
        in_idx = 0; out_idx = 0; done_seen = 0; prev_hold = 0; prev_r = '0;
        stall_left = (mode == 1) ? 4 : 0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            if (glitch && cyc == 1) begin
                START = 1'b1; OP = 2'd2; COUNT = 4'd1;
            end else begin
                START = 1'b0;
            end
            IN_VALID = (in_idx < cnt) && (mode != 2 || $urandom_range(0, 3) != 0);
            A_IN     = (in_idx < cnt) ? a_w[in_idx] : 16'h0;
            B_IN     = (in_idx < cnt) ? b_w[in_idx] : 16'h0;
            if (mode == 1 && R_VALID && stall_left > 0) begin
                R_READY = 1'b0;
                stall_left--;
            end else if (mode == 2) begin
                R_READY = 1'($urandom_range(0, 1));
            end else begin
                R_READY = 1'b1;
            end
            #1;
            if (prev_hold) begin
                chk({name, "_hold_valid"}, {31'd0, R_VALID}, 32'd1);
                chk({name, "_hold_rout"}, {16'd0, R_OUT}, {16'd0, prev_r});
            end
            if (R_VALID && !R_READY)
                chk({name, "_stall_in_ready"}, {31'd0, IN_READY}, 32'd0);
            if (DONE) begin
                chk({name, "_done_after_all"}, 32'(out_idx), 32'(cnt));
                done_seen = 1;
            end
            if (R_VALID && R_READY) begin
                if (out_idx < cnt)
                    chk($sformatf("%s_r_out%0d", name, out_idx), {16'd0, R_OUT}, {16'd0, exp_w[out_idx]});
                else
                    chk({name, "_extra_word"}, 32'(out_idx), 32'(cnt - 1));
                out_idx++;
            end
            if (IN_VALID && IN_READY) in_idx++;
            prev_hold = R_VALID && !R_READY;
            prev_r    = R_OUT;
            @(negedge MasterClock);
        end
        START    = 1'b0;
        IN_VALID = 1'b0;
        if (!done_seen) chk({name, "_done_timeout"}, 32'd0, 32'd1);
        chk({name, "_cf"}, {31'd0, CF}, {31'd0, exp_cf});
        chk({name, "_zf"}, {31'd0, ZF}, {31'd0, exp_zf});
        chk({name, "_vf"}, {31'd0, VF}, {31'd0, exp_vf});
        chk({name, "_idle"}, {30'd0, BUSY, DONE}, 32'd0);
        model_cf = exp_cf;
        $display("op %s: op=%0d count=%0d CF=%0b ZF=%0b VF=%0b", name, op, cnt, CF, ZF, VF);
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; OP = 2'd0; COUNT = 4'd0;
        A_IN = '0; B_IN = '0; IN_VALID = 1'b0; R_READY = 1'b0;
        repeat (2) @(negedge MasterClock);
        chk("reset_outputs", {IN_READY, R_OUT, R_VALID, CF, ZF, VF, BUSY, DONE}, 32'd0);
        RESET = 1'b0;
        @(negedge MasterClock);

        // 1: two-word ADD with carry across words
        a_w[0] = 16'hFFFF; b_w[0] = 16'h0001; a_w[1] = 16'h0001; b_w[1] = 16'h0000;
        run_op("t1_add", 2'd0, 2, 0, 0);
        chk("t1_word1", {16'd0, exp_w[1]}, 32'h0002);

        // 2: SUB with borrow, then SBC consuming it
        a_w[0] = 16'h0000; b_w[0] = 16'h0001;
        run_op("t2_sub", 2'd2, 1, 0, 0);
        a_w[0] = 16'h0005; b_w[0] = 16'h0001;
        run_op("t2_sbc", 2'd3, 1, 0, 0);

        // 3: overflow + zero, then ADC picks up carry
        a_w[0] = 16'h8000; b_w[0] = 16'h8000;
        run_op("t3_add", 2'd0, 1, 0, 0);
        a_w[0] = 16'h0000; b_w[0] = 16'h0000;
        run_op("t3_adc", 2'd1, 1, 0, 0);

        // 4: three words with a 4-cycle downstream stall; START pulsed while busy
        for (int i = 0; i < 3; i++) begin
            a_w[i] = 16'($urandom); b_w[i] = 16'($urandom);
        end
        run_op("t4_stall", 2'd0, 3, 1, 1);

        // 5: leave CF=1, then reset in the middle of a two-word ADD
        a_w[0] = 16'hFFFF; b_w[0] = 16'h0001;
        run_op("t5_setc", 2'd0, 1, 0, 0);
        @(negedge MasterClock);
        START = 1'b1; OP = 2'd0; COUNT = 4'd2;
        @(negedge MasterClock);
        START = 1'b0; IN_VALID = 1'b1; A_IN = 16'h1234; B_IN = 16'h1111; R_READY = 1'b0;
        @(negedge MasterClock);
        IN_VALID = 1'b0;
        #1;
        chk("t5_pre_reset_valid", {31'd0, R_VALID}, 32'd1);
        RESET = 1'b1;
        #1;
        chk("t5_reset_outputs", {IN_READY, R_OUT, R_VALID, CF, ZF, VF, BUSY, DONE}, 32'd0);
        @(negedge MasterClock);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge MasterClock);
            chk("t5_no_done", {30'd0, BUSY, DONE}, 32'd0);
        end
        model_cf = 1'b0;
        a_w[0] = 16'h0005; b_w[0] = 16'h0001;
        run_op("t5_adc", 2'd1, 1, 0, 0);
        chk("t5_adc_word", {16'd0, exp_w[0]}, 32'h0006);

        // 6: START with COUNT=0 is ignored
        @(negedge MasterClock);
        START = 1'b1; OP = 2'd1; COUNT = 4'd0;
        @(negedge MasterClock);
        START = 1'b0;
        #1;
        chk("t6_count0_busy", {31'd0, BUSY}, 32'd0);
        chk("t6_count0_flags", {29'd0, CF, ZF, VF}, {29'd0, exp_cf, exp_zf, exp_vf});
        @(negedge MasterClock);
        chk("t6_count0_done", {31'd0, DONE}, 32'd0);

        // Randomized operations, including full-length and random handshakes
        for (int n = 0; n < 24; n++) begin
            int cnt;
            cnt = (n % 6 == 0) ? 8 : int'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 5))
                    0:       a_w[i] = 16'hFFFF;
                    1:       a_w[i] = 16'h8000;
                    default: a_w[i] = 16'($urandom);
                endcase
                case ($urandom_range(0, 5))
                    0:       b_w[i] = 16'h0000;
                    1:       b_w[i] = 16'h7FFF;
                    default: b_w[i] = 16'($urandom);
                endcase
            end
            run_op($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), cnt,
                   int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
